// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - SPI configuration master for the RX ADC (16-bit frames)
//
// Purpose: turns one register write/read request into a 16-bit SPI frame
// {rw_n, addr[6:0], data[7:0]}, MSB first, and returns read data through a
// single-cycle response pulse.
//
// Ports:
//   CLK, RST_N                  block clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_write/addr/wdata        request contents (wdata ignored on reads)
//   rsp_valid/rsp_rdata         completion pulse and held read data
//   busy                        high from accept until req_ready returns
//   adc_sclk/sclkgate/sen/smosi SPI drive toward the board-level ADC glue
//   adc_smiso                   serial readback from the ADC

module adc_spi_master #(
    parameter int HALF    = 4,
    parameter int FRAME_W = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       adc_sclk,
    output logic       adc_sclkgate,
    output logic       adc_sen,
    output logic       adc_smosi,
    input  logic       adc_smiso
);

    generate
        if (HALF < 2 || HALF > 255 || FRAME_W != 16) begin : g_bad_param
            $error("adc_spi_master: HALF must be 2..255 and FRAME_W must be 16");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_BIT_HI,
        S_BIT_LO,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(HALF - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_idx;
    logic [15:0] r_frame;
    logic [7:0]  r_shift;
    logic        r_ready;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic        r_sclk;
    logic        r_gate;
    logic        r_sen;
    logic        r_smosi;

    logic        w_accept;
    logic        w_cnt_done;
    logic        w_is_read;
    logic [3:0]  w_idx_next;

    // Ready is qualified by RST_N so it reads 0 while reset is held and 1
    // in the very first cycle after release.
    assign req_ready  = r_ready && RST_N;
    assign w_accept   = req_valid && req_ready;
    assign w_cnt_done = (r_cnt == 8'd0);
    assign w_is_read  = r_frame[15];
    assign w_idx_next = r_idx - 4'd1;

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign busy         = r_busy;
    assign adc_sclk     = r_sclk;
    assign adc_sclkgate = r_gate;
    assign adc_sen      = r_sen;
    assign adc_smosi    = r_smosi;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_idx       <= 4'd0;
            r_frame     <= 16'h0000;
            r_shift     <= 8'h00;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_sclk      <= 1'b0;
            r_gate      <= 1'b0;
            r_sen       <= 1'b1;
            r_smosi     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            // Every non-idle state lasts HALF cycles; transitions reload.
            if (r_state != S_IDLE) begin
                r_cnt <= r_cnt - 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_frame <= {~req_write, req_addr, (req_write ? req_wdata : 8'h00)};
                        r_shift <= 8'h00;
                        r_idx   <= 4'd15;
                        r_cnt   <= CNT_RELOAD;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_sen   <= 1'b0;
                        r_gate  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_smosi <= ~req_write;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_cnt   <= CNT_RELOAD;
                        r_gate  <= 1'b1;
                        r_sclk  <= 1'b1;
                        r_smosi <= r_frame[r_idx];
                        r_state <= S_BIT_HI;
                    end
                end
                S_BIT_HI: begin
                    if (w_cnt_done) begin
                        r_cnt   <= CNT_RELOAD;
                        r_sclk  <= 1'b0;
                        r_state <= S_BIT_LO;
                    end
                end
                S_BIT_LO: begin
                    if (w_cnt_done) begin
                        r_cnt <= CNT_RELOAD;
                        // Only the data half of a read frame carries readback.
                        if (w_is_read && !r_idx[3]) begin
                            r_shift[r_idx[2:0]] <= adc_smiso;
                        end
                        if (r_idx == 4'd0) begin
                            r_gate  <= 1'b0;
                            r_sclk  <= 1'b0;
                            r_smosi <= 1'b0;
                            r_state <= S_HOLD;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_sclk  <= 1'b1;
                            r_smosi <= r_frame[w_idx_next];
                            r_state <= S_BIT_HI;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        r_cnt       <= CNT_RELOAD;
                        r_sen       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_shift;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_cnt_done) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
